// File: rtl/zion_rr_arb_pkg.sv
// Shared types and helpers for the round-robin register arbiter.
// Imported by the arbiter RTL and its testbench.
package zion_rr_arb_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } hold_state_e;

    // Fixed-width container for one {id, data} beat; narrower instances use the low bits.
    localparam int unsigned BEAT_ID_MAX  = 8;
    localparam int unsigned BEAT_DAT_MAX = 64;

    typedef struct packed {
        logic [BEAT_ID_MAX-1:0]  id;
        logic [BEAT_DAT_MAX-1:0] dat;
    } beat_t;

    function automatic int unsigned id_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/zion_dff_en_rst.sv
// Enable flop with synchronous active-low reset to a parameterised value.
// Building block for the arbiter holding register and pointer.
module zion_dff_en_rst #(
    parameter int unsigned    W       = 1,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            q <= RST_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/zion_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr, with wrap.
// Produces a one-hot grant (or zero) plus the binary index of the winner.
module zion_rr_pick
    import zion_rr_arb_pkg::*;
#(
    parameter  int unsigned NUM_REQ = 4,
    localparam int unsigned ID_W    = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    idx
);

    logic        found;
    int unsigned pos;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        pos   = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            pos = (32'(ptr) + k) % NUM_REQ;
            if (!found && req[pos]) begin
                found      = 1'b1;
                grant[pos] = 1'b1;
                idx        = ID_W'(pos);
            end
        end
    end

endmodule

// File: rtl/zion_rr_reg_arbiter.sv
// Round-robin arbiter feeding a single valid/ready holding register.
// The winner's data and index are registered; a new beat may replace a draining one each cycle.
module zion_rr_reg_arbiter
    import zion_rr_arb_pkg::*;
#(
    parameter  int unsigned      NUM_REQ  = 4,
    parameter  int unsigned      WIDTH    = 32,
    parameter  logic [WIDTH-1:0] INI_DATA = '0,
    localparam int unsigned      ID_W     = id_width(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       iVld,
    input  logic [NUM_REQ*WIDTH-1:0] iDat,
    output logic [NUM_REQ-1:0]       oRdy,
    output logic                     oVld,
    output logic [WIDTH-1:0]         oDat,
    output logic [ID_W-1:0]          oId,
    input  logic                     iRdy
);

    if (NUM_REQ < 2 || WIDTH < 1) begin : g_bad_param
`ifdef CHECK_ERR_EXIT
        $fatal(1, "zion_rr_reg_arbiter: NUM_REQ must be >= 2 and WIDTH >= 1");
`else
        $error("zion_rr_reg_arbiter: NUM_REQ must be >= 2 and WIDTH >= 1");
`endif
    end

    logic [NUM_REQ-1:0]    grant;
    logic [ID_W-1:0]       win_idx;
    logic [WIDTH-1:0]      win_dat;
    logic [ID_W-1:0]       ptr;
    logic [ID_W-1:0]       ptr_nxt;
    logic                  load;
    logic                  take;
    logic [0:0]            state_q;
    hold_state_e           state;
    hold_state_e           state_nxt;
    logic [ID_W+WIDTH-1:0] hold_q;

    zion_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req   (iVld),
        .ptr   (ptr),
        .grant (grant),
        .idx   (win_idx)
    );

    // Grants are suppressed while reset is asserted so no requester sees an accept that reset discards.
    always_comb begin
        load    = (state == EMPTY) || iRdy;
        oRdy    = grant & {NUM_REQ{load & rst}};
        take    = |oRdy;
        win_dat = iDat[win_idx*WIDTH +: WIDTH];
        ptr_nxt = (win_idx == ID_W'(NUM_REQ - 1)) ? '0 : win_idx + ID_W'(1);
    end

    zion_dff_en_rst #(
        .W       (ID_W + WIDTH),
        .RST_VAL ({{ID_W{1'b0}}, INI_DATA})
    ) u_hold_dat (
        .clk (clk),
        .rst (rst),
        .en  (take),
        .d   ({win_idx, win_dat}),
        .q   (hold_q)
    );

    zion_dff_en_rst #(
        .W       (ID_W),
        .RST_VAL ('0)
    ) u_ptr (
        .clk (clk),
        .rst (rst),
        .en  (take),
        .d   (ptr_nxt),
        .q   (ptr)
    );

    // Holding-stage state register: the valid flop, enabled whenever the stage can load.
    zion_dff_en_rst #(
        .W       (1),
        .RST_VAL (1'b0)
    ) u_hold_vld (
        .clk (clk),
        .rst (rst),
        .en  (load),
        .d   (state_nxt),
        .q   (state_q)
    );

    always_comb begin
        state     = hold_state_e'(state_q);
        state_nxt = state;
        if (load) begin
            state_nxt = take ? FULL : EMPTY;
        end
    end

    always_comb begin
        oVld        = (state == FULL);
        {oId, oDat} = hold_q;
    end

endmodule

// File: doc/zion_rr_reg_arbiter.md
Name: zion_rr_reg_arbiter

Overview:
Shares one output holding register among NUM_REQ requesters. Each requester uses a valid/ready handshake, and the winner is picked by round-robin. The winning requester's data and index are captured into an enable/reset register stage that drives one downstream valid/ready consumer. The block sits between several producer pipelines and a single-ported sink (bus master, shared FIFO write port).

Parameters:
NUM_REQ, 4, number of requesters (>=2)
WIDTH, 32, data width per requester
ID_W, $clog2(NUM_REQ), width of winner index (derived, not overridable)
INI_DATA, '0, reset value of oDat

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous reset, active low
iVld  input  NUM_REQ  per-requester valid
iDat  input  NUM_REQ*WIDTH  packed request data; requester i in bits [i*WIDTH +: WIDTH]
oRdy  output  NUM_REQ  per-requester ready (grant)
oVld  output  1  holding register valid
oDat  output  WIDTH  holding register data
oId  output  ID_W  index of requester whose data is in oDat
iRdy  input  1  downstream ready

Behaviour:
- Interface: one clock (clk); reset is synchronous, active-low (rst). All state updates on posedge clk.
- Reset (rst==0 at posedge):
  - oVld=0, oDat=INI_DATA, oId=0, round-robin pointer ptr=0.
  - Reset overrides every other event; a held beat is discarded.
- Holding stage: two states, EMPTY (oVld=0) and FULL (oVld=1).
  - load = !oVld || iRdy.
- Arbitration (combinational):
  - Among requesters with iVld set, pick the first at or after ptr, scanning upward with wrap (ptr, ptr+1, ..., NUM_REQ-1, 0, ..., ptr-1).
  - grant is one-hot or zero.
  - oRdy = grant & {NUM_REQ{load}}, so at most one bit is set.
  - oRdy depends combinationally on iVld, oVld and iRdy. This path is documented and accepted.
- Transfer in: when any oRdy[i] is set (implies iVld[i]), on the next edge oDat<=iDat[i], oId<=i, oVld<=1, and ptr<=(i+1) mod NUM_REQ.
- Transfer out: when oVld && iRdy with no incoming grant, oVld<=0; oDat and oId hold their values.
- Simultaneous drain and load (oVld && iRdy && a grant): new beat replaces the old in the same cycle. Throughput is 1 beat/clk, latency 1 clk from iVld&&oRdy to oVld.
- Stall (oVld && !iRdy): oRdy=0, and oDat, oId and ptr hold.
- No request: ptr holds.
- Requester contract: iVld and iDat stay stable until oRdy. Not checked in RTL; the bench asserts it.
- Fairness: a continuously requesting requester is granted within NUM_REQ accepted beats.
- Pointer wrap: a grant to NUM_REQ-1 sets ptr=0.
- Parameter check at elaboration: error if NUM_REQ<2 or WIDTH<1. $finish under CHECK_ERR_EXIT.

Decomposition:
- Package zion_rr_arb_pkg: localparam function for ID_W, and a typedef for the {id,data} beat struct used by bench and RTL.
- Sub-module zion_rr_pick: purely combinational. Inputs are req vector and ptr; outputs are one-hot grant and binary index.
- The holding register uses the team's enable/sync-active-low-reset DFF primitive twice:
  - data+id: enable=load && |grant, reset value {0, INI_DATA}.
  - valid bit: enable=load, reset 0.
- ptr is a plain enable DFF, enable=|oRdy.

Test Plan:
(All with NUM_REQ=4, WIDTH=8.)
- Reset: hold rst=0 with iVld=4'hF, iRdy=1 -> oVld=0, oDat=8'h00, oId=0, oRdy=0. After release, first grant goes to requester 0.
- Round-robin: iVld=4'hF constant, iDat lanes 0..3 = 8'hA0..8'hA3, iRdy=1 -> oId sequence 0,1,2,3,0,1 on consecutive cycles, with oDat matching the lane.
- Sparse wrap: only lanes 1 and 3 valid, ptr=2 -> grant 3 first, then 1 (ptr wraps 0 -> 1), then 3.
- Backpressure: iRdy=0 for 5 cycles with oVld=1, oId=2, oDat=8'h55 -> outputs stable and oRdy=4'h0. iRdy=1 -> next granted beat appears the following cycle with no bubble.
- Drain without refill: single beat from lane 2, then iVld=0, iRdy=1 -> oVld drops after one cycle, and oDat/oId retain 8'hxx/2.
- Mid-operation reset: rst=0 while oVld=1, iRdy=0 -> next cycle oVld=0, oDat=INI_DATA, and after release the first winner is lane 0 (ptr cleared).
